// File: rtl/switch_req_debouncer.sv
// Synchronises and debounces N raw switch lines into active-high request levels with rise/fall pulses.
// Optional macro REQ_HOLD_EN: adds an ack port and turns req into a sticky pending bit.
module switch_req_debouncer #(
  parameter int N            = 8,
  parameter int ACTIVE_LOW   = 1,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] raw,
`ifdef REQ_HOLD_EN
  input  logic [N-1:0] ack,
`endif
  output logic [N-1:0] req,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic         changed
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (STABLE_TICKS > 0) ? $clog2(STABLE_TICKS + 1) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [N-1:0]  lvl;
  logic [N-1:0]  s1_reg;
  logic [N-1:0]  s2_reg;
  logic [N-1:0]  deb_reg;
  logic [N-1:0]  rise_reg;
  logic [N-1:0]  fall_reg;
  logic          changed_reg;
  logic [N-1:0]  differ;
  logic [N-1:0]  accept;
  logic [PW-1:0] pre_reg;
  logic          tick;
  logic [CW-1:0] cnt_reg  [N];
  logic [CW-1:0] cnt_next [N];

  assign lvl  = (ACTIVE_LOW != 0) ? ~raw : raw;
  assign tick = (pre_reg == PRE_LAST);

  // Two-flop synchroniser and the shared free-running tick prescaler.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg  <= '0;
      s2_reg  <= '0;
      pre_reg <= '0;
    end else begin
      s1_reg  <= lvl;
      s2_reg  <= s1_reg;
      pre_reg <= tick ? '0 : pre_reg + 1'b1;
    end
  end

  // Any sample agreeing with the accepted level restarts that channel's count.
  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    assign differ[gi]   = s2_reg[gi] ^ deb_reg[gi];
    assign accept[gi]   = differ[gi] & tick & (cnt_reg[gi] == CNT_LAST);
    assign cnt_next[gi] = (!differ[gi] || accept[gi]) ? '0
                        : (tick ? cnt_reg[gi] + 1'b1 : cnt_reg[gi]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_reg     <= '0;
      rise_reg    <= '0;
      fall_reg    <= '0;
      changed_reg <= 1'b0;
      for (int i = 0; i < N; i++) begin
        cnt_reg[i] <= '0;
      end
    end else begin
      deb_reg     <= deb_reg ^ accept;
      rise_reg    <= accept & s2_reg;
      fall_reg    <= accept & ~s2_reg;
      changed_reg <= |accept;
      cnt_reg     <= cnt_next;
    end
  end

`ifdef REQ_HOLD_EN
  logic [N-1:0] pend_reg;

  // A rise in the same cycle as an ack keeps the request pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_reg <= '0;
    end else begin
      pend_reg <= (pend_reg & ~ack) | rise_reg;
    end
  end

  assign req = pend_reg;
`else
  assign req = deb_reg;
`endif

  assign rise    = rise_reg;
  assign fall    = fall_reg;
  assign changed = changed_reg;

endmodule
